// File: rtl/pwm_multichannel.sv
// pwm_multichannel
//   Multi-channel PWM generator. One shared counter drives CHANNELS
//   comparators. The counter runs edge-aligned (0..max, wrap) or
//   centre-aligned (0..max..1, then 0). Duty, period and mode are held in
//   shadow registers that only change at a period boundary, so a period in
//   progress is never disturbed.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   enable        1 = run; 0 = counter held at 0, outputs low
//   load          one-cycle request to refresh the shadow registers
//   mode          0 = edge-aligned, 1 = centre-aligned (shadowed)
//   max_value     period terminal count (shadowed)
//   duty_flat     channel i duty at duty_flat[i*WIDTH +: WIDTH] (shadowed)
//   pwm_out       registered PWM outputs, one per channel
//   period_start  one-cycle pulse while pwm_out reflects cnt = 0
//   load_ack      one-cycle pulse after the shadow registers were refreshed
//
// Load handshake: a load pulse arms 'pending'; further pulses while armed
// are absorbed. The shadows sample mode/max_value/duty_flat in the last
// cycle of a period (or on any cycle while disabled) when pending or load
// is high, and load_ack pulses in the following cycle. The driver keeps
// the inputs stable from load until load_ack.
module pwm_multichannel #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      load,
  input  logic                      mode,
  input  logic [WIDTH-1:0]          max_value,
  input  logic [CHANNELS*WIDTH-1:0] duty_flat,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start,
  output logic                      load_ack
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [WIDTH-1:0]          cnt;
  logic [WIDTH-1:0]          cnt_nxt;
  dir_e                      dir;
  dir_e                      dir_nxt;
  logic [WIDTH-1:0]          max_sh;
  logic                      mode_sh;
  logic [CHANNELS*WIDTH-1:0] duty_sh;
  logic                      pending;
  logic                      at_max;
  logic                      boundary;
  logic                      apply;
  logic [CHANNELS-1:0]       pwm_nxt;

  assign at_max = (cnt == max_sh);

  // Last cycle of a period. In centre mode the turn-around cycle (cnt==max)
  // already counts as "heading down", which makes max==1 give the 0,1
  // sequence with a boundary at cnt==1.
  always_comb begin
    boundary = 1'b0;
    if (!mode_sh) begin
      boundary = at_max;
    end else begin
      boundary = ((cnt == ONE) && ((dir == DIR_DOWN) || at_max)) ||
                 (max_sh == '0);
    end
  end

  assign apply = (pending || load) && (boundary || !enable);

  // Counter/direction next state. A boundary or a disabled cycle always
  // restarts at cnt=0 counting up, which is also where a mode change lands.
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (!enable || boundary) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (!mode_sh) begin
      cnt_nxt = cnt + ONE;
    end else if (dir == DIR_DOWN) begin
      cnt_nxt = cnt - ONE;
    end else if (at_max) begin
      cnt_nxt = cnt - ONE;
      dir_nxt = DIR_DOWN;
    end else begin
      cnt_nxt = cnt + ONE;
    end
  end

  always_comb begin
    pwm_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_nxt[i] = enable && (cnt < duty_sh[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      dir          <= DIR_UP;
      max_sh       <= '0;
      mode_sh      <= 1'b0;
      duty_sh      <= '0;
      pending      <= 1'b0;
      pwm_out      <= '0;
      period_start <= 1'b0;
      load_ack     <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      dir          <= dir_nxt;
      pwm_out      <= pwm_nxt;
      period_start <= enable && (cnt == '0);
      load_ack     <= apply;
      if (apply) begin
        mode_sh <= mode;
        max_sh  <= max_value;
        duty_sh <= duty_flat;
        pending <= 1'b0;
      end else begin
        pending <= pending || load;
      end
    end
  end

endmodule
